// File: rtl/branch_sequencer_if.sv
// Branch sequencer bus interface.
// Bundles the request inputs (start, condition code, operand bus) together
// with the datapath control strobes and status returned by the sequencer.
// The master modport belongs to the requester; the slave modport belongs to
// the sequencer.

interface branch_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [2:0]            cond_code;
    logic [DATA_WIDTH-1:0] bus_data;

    logic                  gra;
    logic                  r_out;
    logic                  pc_out;
    logic                  y_in;
    logic                  c_out;
    logic                  z_in;
    logic                  z_low_out;
    logic                  pc_in;
    logic [3:0]            alu_op;
    logic                  busy;
    logic                  done;
    logic                  con_out;

    modport master (
        output start, cond_code, bus_data,
        input  gra, r_out, pc_out, y_in, c_out, z_in, z_low_out, pc_in,
        input  alu_op, busy, done, con_out
    );

    modport slave (
        input  start, cond_code, bus_data,
        output gra, r_out, pc_out, y_in, c_out, z_in, z_low_out, pc_in,
        output alu_op, busy, done, con_out
    );
endinterface

// File: rtl/branch_sequencer.sv
// Branch sequencer: walks a conditional-branch micro-sequence
// (IDLE -> EVAL -> PCY -> ADD -> WB, or EVAL -> FIN on an early exit) and
// drives the datapath strobes as registered Moore outputs of the state.
// Optional statistics counters are enabled by defining the macro
// BRANCH_SEQUENCER_STATS_EN; without it the block has no statistics ports.

module branch_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter bit EARLY_EXIT  = 1'b0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
`ifdef BRANCH_SEQUENCER_STATS_EN
    input  logic                   clear_stats,
    output logic [COUNT_WIDTH-1:0] taken_count,
    output logic [COUNT_WIDTH-1:0] not_taken_count,
`endif
    branch_sequencer_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        PCY,
        ADD,
        WB,
        FIN
    } state_t;

    typedef struct packed {
        logic       gra;
        logic       r_out;
        logic       pc_out;
        logic       y_in;
        logic       c_out;
        logic       z_in;
        logic       z_low_out;
        logic       pc_in;
        logic [3:0] alu_op;
        logic       busy;
        logic       done;
    } strobes_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;

    state_t   state;
    strobes_t outs;
    logic [2:0] cond_q;
    logic       con_q;
    logic       cond_now;
    logic       skip_add;

    if (COUNT_WIDTH < 1) begin : g_bad_count_width
        $error("branch_sequencer: COUNT_WIDTH must be at least 1");
    end

    // Evaluate a condition code against an operand value.
    function automatic logic decode_cond(input logic [2:0] code,
                                         input logic [DATA_WIDTH-1:0] data);
        logic is_zero;
        logic msb;
        is_zero = (data == '0);
        msb     = data[DATA_WIDTH-1];
        case (code)
            3'b000:  return is_zero;
            3'b001:  return !is_zero;
            3'b010:  return !msb;
            3'b011:  return msb;
            3'b100:  return 1'b1;
            3'b101:  return 1'b0;
            3'b110:  return !msb && !is_zero;
            default: return msb || is_zero;
        endcase
    endfunction

    // Strobe pattern belonging to a state; pc_in follows the stored condition.
    function automatic strobes_t strobes_for(input state_t s, input logic con);
        strobes_t o;
        o = '0;
        case (s)
            EVAL: begin
                o.gra   = 1'b1;
                o.r_out = 1'b1;
            end
            PCY: begin
                o.pc_out = 1'b1;
                o.y_in   = 1'b1;
            end
            ADD: begin
                o.c_out  = 1'b1;
                o.z_in   = 1'b1;
                o.alu_op = ALU_ADD;
            end
            WB: begin
                o.z_low_out = 1'b1;
                o.pc_in     = con;
                o.done      = 1'b1;
            end
            FIN: begin
                o.done = 1'b1;
            end
            default: begin
            end
        endcase
        o.busy = (s != IDLE);
        return o;
    endfunction

    // Live condition of the operand bus, used only at the EVAL-exit edge.
    assign cond_now = decode_cond(cond_q, bus.bus_data);
    assign skip_add = EARLY_EXIT && !cond_now;

    // Sequencer state plus registered strobes loaded with the next state's pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            outs   <= '0;
            cond_q <= 3'b000;
            con_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cond_q <= bus.cond_code;
                        state  <= EVAL;
                        outs   <= strobes_for(EVAL, con_q);
                    end
                end
                EVAL: begin
                    con_q <= cond_now;
                    if (skip_add) begin
                        state <= FIN;
                        outs  <= strobes_for(FIN, cond_now);
                    end else begin
                        state <= PCY;
                        outs  <= strobes_for(PCY, cond_now);
                    end
                end
                PCY: begin
                    state <= ADD;
                    outs  <= strobes_for(ADD, con_q);
                end
                ADD: begin
                    state <= WB;
                    outs  <= strobes_for(WB, con_q);
                end
                WB, FIN: begin
                    state <= IDLE;
                    outs  <= strobes_for(IDLE, con_q);
                end
                default: begin
                    state <= IDLE;
                    outs  <= '0;
                end
            endcase
        end
    end

`ifdef BRANCH_SEQUENCER_STATS_EN
    // Taken / not-taken tallies, bumped at each EVAL exit; clear has priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_count     <= '0;
            not_taken_count <= '0;
        end else if (clear_stats) begin
            taken_count     <= '0;
            not_taken_count <= '0;
        end else if (state == EVAL) begin
            if (cond_now) begin
                taken_count <= taken_count + COUNT_WIDTH'(1);
            end else begin
                not_taken_count <= not_taken_count + COUNT_WIDTH'(1);
            end
        end
    end
`endif

    assign bus.gra       = outs.gra;
    assign bus.r_out     = outs.r_out;
    assign bus.pc_out    = outs.pc_out;
    assign bus.y_in      = outs.y_in;
    assign bus.c_out     = outs.c_out;
    assign bus.z_in      = outs.z_in;
    assign bus.z_low_out = outs.z_low_out;
    assign bus.pc_in     = outs.pc_in;
    assign bus.alu_op    = outs.alu_op;
    assign bus.busy      = outs.busy;
    assign bus.done      = outs.done;
    assign bus.con_out   = con_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Testbench for branch_sequencer. Two instances run side by side: dut0 with
// EARLY_EXIT=0 and dut1 with EARLY_EXIT=1, sharing condition code and bus
// data but with separate start lines. Expected cycle traces, condition
// results and statistics come from a behavioural model in this file.

module tb_branch_sequencer;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start0;
    logic          start1;
    logic [2:0]    cond_code;
    logic [DW-1:0] bus_data;
`ifdef BRANCH_SEQUENCER_STATS_EN
    logic          clear_stats;
    logic [CW-1:0] tc0, ntc0, tc1, ntc1;
`endif

    int checks = 0;
    int errors = 0;

    // Model state per instance: last condition result and counter values.
    logic con_m [2];
    int   tk_m  [2];
    int   nt_m  [2];

    // Per-cycle captures of the most recent sequence.
    logic [13:0] cap0  [1:5];
    logic [13:0] cap1  [1:5];
    logic        capc0 [1:5];
    logic        capc1 [1:5];

    always #5 clk = ~clk;

    branch_sequencer_if #(.DATA_WIDTH(DW)) bus0 ();
    branch_sequencer_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.start     = start0;
    assign bus0.cond_code = cond_code;
    assign bus0.bus_data  = bus_data;
    assign bus1.start     = start1;
    assign bus1.cond_code = cond_code;
    assign bus1.bus_data  = bus_data;

    branch_sequencer #(.DATA_WIDTH(DW), .EARLY_EXIT(1'b0), .COUNT_WIDTH(CW)) dut0 (
        .clk             (clk),
        .reset_n         (reset_n),
`ifdef BRANCH_SEQUENCER_STATS_EN
        .clear_stats     (clear_stats),
        .taken_count     (tc0),
        .not_taken_count (ntc0),
`endif
        .bus             (bus0.slave)
    );

    branch_sequencer #(.DATA_WIDTH(DW), .EARLY_EXIT(1'b1), .COUNT_WIDTH(CW)) dut1 (
        .clk             (clk),
        .reset_n         (reset_n),
`ifdef BRANCH_SEQUENCER_STATS_EN
        .clear_stats     (clear_stats),
        .taken_count     (tc1),
        .not_taken_count (ntc1),
`endif
        .bus             (bus1.slave)
    );

    // Observed word: {gra,r_out,pc_out,y_in,c_out,z_in,z_low_out,pc_in,alu_op,busy,done}
    wire [13:0] obs0 = {bus0.gra, bus0.r_out, bus0.pc_out, bus0.y_in, bus0.c_out,
                        bus0.z_in, bus0.z_low_out, bus0.pc_in, bus0.alu_op,
                        bus0.busy, bus0.done};
    wire [13:0] obs1 = {bus1.gra, bus1.r_out, bus1.pc_out, bus1.y_in, bus1.c_out,
                        bus1.z_in, bus1.z_low_out, bus1.pc_in, bus1.alu_op,
                        bus1.busy, bus1.done};

    // Branch condition straight from the decode table, using signed arithmetic.
    function automatic logic cond_true(input logic [2:0] c, input logic [DW-1:0] d);
        case (c)
            3'd0:    return d == 0;
            3'd1:    return d != 0;
            3'd2:    return $signed(d) >= 0;
            3'd3:    return $signed(d) < 0;
            3'd4:    return 1'b1;
            3'd5:    return 1'b0;
            3'd6:    return $signed(d) > 0;
            default: return $signed(d) <= 0;
        endcase
    endfunction

    // Expected output word in cycle cyc after start was sampled (1 = EVAL).
    function automatic logic [13:0] expect_word(input bit early, input int cyc, input logic t);
        if (cyc == 1) return {8'b1100_0000, 4'h0, 2'b10};
        if (early && !t) return (cyc == 2) ? {8'h00, 4'h0, 2'b11} : 14'h0;
        case (cyc)
            2:       return {8'b0011_0000, 4'h0, 2'b10};
            3:       return {8'b0000_1100, 4'h2, 2'b10};
            4:       return {6'b000000, 1'b1, t, 4'h0, 2'b11};
            default: return 14'h0;
        endcase
    endfunction

    // Advance the model after one completed evaluation on instance u.
    function automatic void model_step(input int u, input logic t, input logic clr);
        con_m[u] = t;
        if (clr) begin
            tk_m[u] = 0;
            nt_m[u] = 0;
        end else if (t) begin
            tk_m[u] = (tk_m[u] + 1) % (1 << CW);
        end else begin
            nt_m[u] = (nt_m[u] + 1) % (1 << CW);
        end
    endfunction

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            con_m[u] = 1'b0;
            tk_m[u]  = 0;
            nt_m[u]  = 0;
        end
    endfunction

    function automatic logic [DW-1:0] pick_data();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return DW'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    // Start both instances on one branch and capture five cycles of outputs.
    // Called at a falling edge; returns at a falling edge with both idle.
    task automatic drive_pair(input logic [2:0] c, input logic [DW-1:0] d,
                              input bit noisy, input bit clr);
        int last1;
        last1     = cond_true(c, d) ? 4 : 2;
        cond_code = c;
        bus_data  = d;
        start0    = 1'b1;
        start1    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            cap0[k]  = obs0;
            cap1[k]  = obs1;
            capc0[k] = bus0.con_out;
            capc1[k] = bus1.con_out;
            start0   = (noisy && k <= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            start1   = (noisy && k <= last1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k >= 2) bus_data = $urandom;
`ifdef BRANCH_SEQUENCER_STATS_EN
            clear_stats = clr && (k == 1);
`endif
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        start0    = 1'b0;
        start1    = 1'b0;
        cond_code = 3'b000;
        bus_data  = '0;
`ifdef BRANCH_SEQUENCER_STATS_EN
        clear_stats = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs0 !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_outs0 got %b want %b", obs0, 14'h0);
        end
        checks++;
        if (obs1 !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_outs1 got %b want %b", obs1, 14'h0);
        end
        checks++;
        if ({bus0.con_out, bus1.con_out} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_con got %b want 00", {bus0.con_out, bus1.con_out});
        end
`ifdef BRANCH_SEQUENCER_STATS_EN
        checks++;
        if ({tc0, ntc0, tc1, ntc1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_stats got %h want 0", {tc0, ntc0, tc1, ntc1});
        end
`endif
        reset_n = 1'b1;
    endtask

    // Hand-picked condition / operand pairs, including the signed-compare edges.
    task automatic test_directed();
        logic [2:0]    dc [8] = '{3'b000, 3'b011, 3'b110, 3'b110, 3'b110, 3'b101, 3'b111, 3'b010};
        logic [DW-1:0] dd [8] = '{32'h0, 32'h1, 32'h8000_0000, 32'h0, 32'h5,
                                  32'h1234, 32'h0, 32'h7FFF_FFFF};
        logic t;
        for (int i = 0; i < 8; i++) begin
            t = cond_true(dc[i], dd[i]);
            drive_pair(dc[i], dd[i], 1'b0, 1'b0);
            for (int k = 1; k <= 5; k++) begin
                checks++;
                if (cap0[k] !== expect_word(1'b0, k, t)) begin
                    errors++;
                    $display("[TB] FAIL dir%0d_dut0_cyc%0d got %b want %b", i, k, cap0[k], expect_word(1'b0, k, t));
                end
                checks++;
                if (cap1[k] !== expect_word(1'b1, k, t)) begin
                    errors++;
                    $display("[TB] FAIL dir%0d_dut1_cyc%0d got %b want %b", i, k, cap1[k], expect_word(1'b1, k, t));
                end
                checks++;
                if (capc0[k] !== ((k == 1) ? con_m[0] : t)) begin
                    errors++;
                    $display("[TB] FAIL dir%0d_con0_cyc%0d got %b want %b", i, k, capc0[k], (k == 1) ? con_m[0] : t);
                end
                checks++;
                if (capc1[k] !== ((k == 1) ? con_m[1] : t)) begin
                    errors++;
                    $display("[TB] FAIL dir%0d_con1_cyc%0d got %b want %b", i, k, capc1[k], (k == 1) ? con_m[1] : t);
                end
            end
            model_step(0, t, 1'b0);
            model_step(1, t, 1'b0);
        end
    endtask

    // Random branches with spurious start pulses while busy.
    task automatic test_random();
        logic [2:0]    c;
        logic [DW-1:0] d;
        logic          t;
        for (int i = 0; i < 24; i++) begin
            c = 3'($urandom_range(0, 7));
            d = pick_data();
            t = cond_true(c, d);
            drive_pair(c, d, 1'b1, 1'b0);
            for (int k = 1; k <= 5; k++) begin
                checks++;
                if (cap0[k] !== expect_word(1'b0, k, t) || cap1[k] !== expect_word(1'b1, k, t)) begin
                    errors++;
                    $display("[TB] FAIL rnd%0d_cyc%0d cond %b data %h got %b/%b want %b/%b", i, k, c, d,
                             cap0[k], cap1[k], expect_word(1'b0, k, t), expect_word(1'b1, k, t));
                end
                checks++;
                if ({capc0[k], capc1[k]} !== ((k == 1) ? {con_m[0], con_m[1]} : {t, t})) begin
                    errors++;
                    $display("[TB] FAIL rnd%0d_con_cyc%0d got %b%b want %b", i, k, capc0[k], capc1[k],
                             (k == 1) ? {con_m[0], con_m[1]} : {t, t});
                end
            end
            model_step(0, t, 1'b0);
            model_step(1, t, 1'b0);
        end
    endtask

    // start held through the done cycle: one IDLE cycle, then a fresh EVAL.
    task automatic test_back_to_back();
        logic [13:0] exp;
        cond_code = 3'b100;
        bus_data  = $urandom;
        start0    = 1'b1;
        start1    = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = (k <= 4) ? expect_word(1'b0, k, 1'b1) :
                  (k == 5) ? 14'h0 : expect_word(1'b0, k - 5, 1'b1);
            checks++;
            if (obs0 !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_cyc%0d got %b want %b", k, obs0, exp);
            end
            checks++;
            if (obs1 !== 14'h0) begin
                errors++;
                $display("[TB] FAIL b2b_other_idle_cyc%0d got %b want %b", k, obs1, 14'h0);
            end
            start0 = (k <= 5);
        end
        model_step(0, 1'b1, 1'b0);
        model_step(0, 1'b1, 1'b0);
    endtask

    // Reset asserted during ADD clears everything at once; then a normal run.
    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic          t;
        cond_code = 3'b100;
        bus_data  = $urandom;
        start0    = 1'b1;
        start1    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
        end
        checks++;
        if (obs0 !== expect_word(1'b0, 3, 1'b1)) begin
            errors++;
            $display("[TB] FAIL pre_reset_add got %b want %b", obs0, expect_word(1'b0, 3, 1'b1));
        end
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs0 !== 14'h0 || obs1 !== 14'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outs got %b/%b want 0/0", obs0, obs1);
        end
        checks++;
        if ({bus0.con_out, bus1.con_out} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mid_reset_con got %b%b want 00", bus0.con_out, bus1.con_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        d = 32'h0000_0000;
        t = cond_true(3'b001, d);
        drive_pair(3'b001, d, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (cap0[k] !== expect_word(1'b0, k, t) || cap1[k] !== expect_word(1'b1, k, t)) begin
                errors++;
                $display("[TB] FAIL post_reset_cyc%0d got %b/%b want %b/%b", k, cap0[k], cap1[k],
                         expect_word(1'b0, k, t), expect_word(1'b1, k, t));
            end
        end
        model_step(0, t, 1'b0);
        model_step(1, t, 1'b0);
    endtask

`ifdef BRANCH_SEQUENCER_STATS_EN
    // Counter wrap with a 2-bit width and clear winning over an increment.
    task automatic test_stats();
        drive_pair(3'b101, 32'h0, 1'b0, 1'b1);
        model_step(0, 1'b0, 1'b1);
        model_step(1, 1'b0, 1'b1);
        checks++;
        if ({tc0, ntc0, tc1, ntc1} !== '0) begin
            errors++;
            $display("[TB] FAIL stats_clear1 got %h want 0", {tc0, ntc0, tc1, ntc1});
        end
        for (int i = 0; i < 5; i++) begin
            drive_pair(3'b100, $urandom, 1'b0, 1'b0);
            model_step(0, 1'b1, 1'b0);
            model_step(1, 1'b1, 1'b0);
        end
        checks++;
        if (tc0 !== CW'(tk_m[0]) || tc1 !== CW'(tk_m[1])) begin
            errors++;
            $display("[TB] FAIL stats_taken_wrap got %0d/%0d want %0d", tc0, tc1, tk_m[0]);
        end
        checks++;
        if (ntc0 !== CW'(nt_m[0]) || ntc1 !== CW'(nt_m[1])) begin
            errors++;
            $display("[TB] FAIL stats_not_taken got %0d/%0d want %0d", ntc0, ntc1, nt_m[0]);
        end
        drive_pair(3'b000, 32'h0, 1'b0, 1'b1);
        model_step(0, 1'b1, 1'b1);
        model_step(1, 1'b1, 1'b1);
        checks++;
        if ({tc0, ntc0, tc1, ntc1} !== '0) begin
            errors++;
            $display("[TB] FAIL stats_clear_at_eval got %h want 0", {tc0, ntc0, tc1, ntc1});
        end
        for (int i = 0; i < 6; i++) begin
            logic [2:0]    c;
            logic [DW-1:0] d;
            c = 3'($urandom_range(0, 7));
            d = pick_data();
            drive_pair(c, d, 1'b1, 1'b0);
            model_step(0, cond_true(c, d), 1'b0);
            model_step(1, cond_true(c, d), 1'b0);
        end
        checks++;
        if (tc0 !== CW'(tk_m[0]) || ntc0 !== CW'(nt_m[0]) ||
            tc1 !== CW'(tk_m[1]) || ntc1 !== CW'(nt_m[1])) begin
            errors++;
            $display("[TB] FAIL stats_random got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     tc0, ntc0, tc1, ntc1, tk_m[0], nt_m[0], tk_m[1], nt_m[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef BRANCH_SEQUENCER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of the bus operand tested for the branch condition.
REQ-002 Parameter: EARLY_EXIT, default 0; 1 = not-taken branch skips the PC-add steps.
REQ-003 Parameter: COUNT_WIDTH, default 16, width of the statistics counters.
REQ-004 Port: clk  in  1  system clock; all state changes on the rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  request to execute one branch sequence.
REQ-007 Port: cond_code  in  3  branch condition, sampled with start.
REQ-008 Port: bus_data  in  DATA_WIDTH  datapath bus value, sampled during EVAL.
REQ-009 Port: gra, r_out, pc_out, y_in, c_out, z_in, z_low_out, pc_in  out  1 each  datapath control strobes.
REQ-010 Port: alu_op  out  4  ALU operation select.
REQ-011 Port: busy  out  1  high whenever state is not IDLE.
REQ-012 Port: done  out  1  one-cycle completion pulse.
REQ-013 Port: con_out  out  1  registered branch-condition result.

Function
REQ-014 cond_code decode SHALL be: 000 zero; 001 nonzero; 010 MSB=0; 011 MSB=1; 100 always; 101 never; 110 signed >0 (MSB=0 and nonzero); 111 signed <=0.
REQ-015 States SHALL be IDLE, EVAL, PCY, ADD, WB, FIN.
REQ-016 In IDLE, start=1 at an edge SHALL latch cond_code and move to EVAL.
REQ-017 EVAL SHALL assert gra=1 and r_out=1.
REQ-018 At the EVAL-exit edge, con_out SHALL load the decoded condition of bus_data.
REQ-019 EVAL SHALL go to PCY, except that it SHALL go to FIN when EARLY_EXIT=1 and the condition is false.
REQ-020 PCY SHALL assert pc_out=1 and y_in=1, then go to ADD.
REQ-021 ADD SHALL assert c_out=1, z_in=1 and alu_op=4'b0010, then go to WB.
REQ-022 WB SHALL assert z_low_out=1, pc_in=con_out and done=1, then go to IDLE.
REQ-023 FIN SHALL assert done=1 with all strobes 0, then go to IDLE.
REQ-024 Outside ADD, alu_op SHALL be 4'b0000; strobes not listed for a state SHALL be 0.
REQ-025 All strobe outputs SHALL be Moore decodes of the state, glitch-free and registered-state based.
REQ-026 start while busy=1 SHALL be ignored, not queued.
REQ-027 Latency: taken or EARLY_EXIT=0 SHALL give done 4 cycles after start is sampled; early exit SHALL give done 2 cycles after.
REQ-028 start may be high in the same cycle done is high; the new sequence SHALL begin at the edge after that cycle (IDLE first).
REQ-029 con_out SHALL hold its value until the next EVAL.

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE, all outputs 0, con_out 0 and the latched cond_code 000, including mid-sequence.
REQ-031 After reset release, the first start SHALL be accepted on the first rising edge with reset_n=1.

Configuration
REQ-032 Macro BRANCH_SEQUENCER_STATS_EN SHALL gate the statistics feature.
REQ-033 With BRANCH_SEQUENCER_STATS_EN defined: extra ports clear_stats (in, 1), taken_count and not_taken_count (out, COUNT_WIDTH) SHALL exist.
REQ-034 With the macro defined, the matching counter SHALL increment by 1 at each EVAL-exit edge and wrap modulo 2^COUNT_WIDTH.
REQ-035 With the macro defined, clear_stats=1 SHALL zero both counters synchronously and SHALL win over a simultaneous increment.
REQ-036 With the macro defined, reset SHALL zero both counters.
REQ-037 Without the macro, those ports and counters SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-038 cond 000, bus_data=0, EARLY_EXIT=0 -> EVAL,PCY,ADD,WB in order; con_out=1; pc_in=1 only in WB; done at cycle 4.
REQ-039 cond 011, bus_data=32'h00000001, EARLY_EXIT=1 -> con_out=0; FIN follows EVAL; done at cycle 2; pc_out, y_in, z_in never asserted.
REQ-040 cond 110 with bus_data=32'h80000000, then 32'h00000000, then 32'h00000005 -> con_out 0, 0, 1 respectively.
REQ-041 start pulses during PCY and ADD -> ignored; exactly one done; start held through the done cycle -> next EVAL two cycles after done.
REQ-042 reset_n low during ADD -> all strobes 0 and busy 0 immediately; after release, start -> normal 4-cycle sequence.
REQ-043 STATS_EN with COUNT_WIDTH=2: 5 taken branches -> taken_count=1; clear_stats at an EVAL-exit edge -> both counters 0.
